// File: rtl/rc4_stream_xor_pkg.sv
// Shared types for the RC4 keystream consumer.
// Holds the FSM state set and the byte type.
package rc4_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_INIT = 3'd1,
    START     = 3'd2,
    DROP      = 3'd3,
    COLLECT   = 3'd4,
    DRAIN     = 3'd5
  } state_e;

  localparam int unsigned STALE_DISCARD = 1;

endpackage

// File: rtl/rc4_stream_xor_fifo.sv
// Single-clock keystream byte FIFO, depth 2^AW.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module rc4_byte_fifo
  import rc4_pkg::*;
#(
  parameter int AW = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        push,
  input  logic        pop,
  input  byte_t       din,
  output byte_t       dout,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  byte_t         mem_q [2**AW];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push;
  logic          do_pop;

  assign empty   = cnt_q == '0;
  assign full    = cnt_q == DEPTH;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_q];
  assign count   = cnt_q;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (clr) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
      if (do_push && !do_pop) begin
        cnt_d = cnt_q + 1'b1;
      end else if (do_pop && !do_push) begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/rc4_stream_xor.sv
// RC4 keystream consumer: buffers keystream and XORs it onto a byte stream.
// Define RC4_DROP_EN to discard DROP_N bytes after the stale one (RC4-drop[N]).
module rc4_stream_xor
  import rc4_pkg::*;
#(
  parameter int KS_AW = 4,
  parameter int LEN_W = 16
`ifdef RC4_DROP_EN
  ,
  parameter int DROP_N = 256
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_start,
  input  logic [LEN_W-1:0] frame_len,
  output logic             busy,
  input  logic             ks_init_done,
  output logic             ks_rdy,
  input  logic             ks_valid,
  input  byte_t            ks_byte,
  output logic             ks_done,
  input  logic             in_valid,
  output logic             in_ready,
  input  byte_t            in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output byte_t            out_data,
  output logic             out_last,
  output logic             ks_ovf
);

`ifdef RC4_DROP_EN
  localparam int DROP_W = $clog2(DROP_N + 1);
  logic [DROP_W-1:0] drop_q, drop_d;
`endif

  state_e           state_q, state_d;
  logic [LEN_W-1:0] rem_ks_q, rem_ks_d;
  logic [LEN_W-1:0] rem_dat_q, rem_dat_d;
  logic [1:0]       stale_q, stale_d;
  logic             ks_done_q, ks_done_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  byte_t            out_data_q, out_data_d;

  logic             dp_act;
  logic             xfer;
  logic             keep;
  logic             ovf_hit;
  logic             fifo_clr;
  logic             fifo_full;
  logic             fifo_empty;
  byte_t            fifo_dout;
  logic [KS_AW:0]   fifo_cnt;
  logic             unused_cnt;

  assign unused_cnt = ^fifo_cnt;

  rc4_byte_fifo #(
    .AW(KS_AW)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .clr  (fifo_clr),
    .push (keep),
    .pop  (xfer),
    .din  (ks_byte),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_cnt)
  );

  assign dp_act   = (state_q == COLLECT) || (state_q == DRAIN);
  assign busy     = state_q != IDLE;
  assign ks_rdy   = state_q == START;
  assign in_ready = dp_act && !fifo_empty
                 && (!out_valid_q || out_ready)
                 && (rem_dat_q != '0);
  assign xfer     = in_valid && in_ready;
  assign keep     = (state_q == COLLECT) && ks_valid;
  assign ovf_hit  = keep && fifo_full && !xfer;
  assign fifo_clr = (state_q == IDLE) && frame_start
                 && (frame_len != '0);

  always_comb begin
    state_d   = state_q;
    rem_ks_d  = rem_ks_q;
    rem_dat_d = rem_dat_q;
    stale_d   = stale_q;
    ks_done_d = 1'b0;
    ovf_d     = ovf_q | ovf_hit;
`ifdef RC4_DROP_EN
    drop_d    = drop_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (fifo_clr) begin
          rem_ks_d  = frame_len;
          rem_dat_d = frame_len;
          stale_d   = 2'(STALE_DISCARD);
          state_d   = WAIT_INIT;
        end
      end
      WAIT_INIT: begin
        if (ks_init_done) state_d = START;
      end
      START: begin
        // leading strobes carry stale generator output
        if (ks_valid) begin
          stale_d = stale_q - 1'b1;
          if (stale_q == 2'd1) begin
`ifdef RC4_DROP_EN
            drop_d  = DROP_W'(DROP_N);
            state_d = (DROP_N == 0) ? COLLECT : DROP;
`else
            state_d = COLLECT;
`endif
          end
        end
      end
      DROP: begin
`ifdef RC4_DROP_EN
        if (ks_valid) begin
          drop_d = drop_q - 1'b1;
          if (drop_q == DROP_W'(1)) state_d = COLLECT;
        end
`endif
      end
      COLLECT: begin
        if (ks_valid) begin
          rem_ks_d = rem_ks_q - 1'b1;
          if (rem_ks_q == LEN_W'(1)) begin
            ks_done_d = 1'b1;
            state_d   = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (rem_dat_q == '0 && !out_valid_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (xfer) rem_dat_d = rem_dat_q - 1'b1;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data ^ fifo_dout;
      out_last_d  = rem_dat_q == LEN_W'(1);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      rem_ks_q    <= '0;
      rem_dat_q   <= '0;
      stale_q     <= '0;
      ks_done_q   <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rem_ks_q    <= rem_ks_d;
      rem_dat_q   <= rem_dat_d;
      stale_q     <= stale_d;
      ks_done_q   <= ks_done_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

`ifdef RC4_DROP_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) drop_q <= '0;
    else      drop_q <= drop_d;
  end
`endif

  assign ks_done   = ks_done_q;
  assign ks_ovf    = ovf_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_rc4_stream_xor.sv
// Directed bench for rc4_stream_xor: frames, backpressure, overflow,
// zero length, busy restart, mid-frame reset and optional drop.
module tb_rc4_stream_xor;

  logic        clk = 0;
  logic        rst = 1;
  logic        frame_start = 0;
  logic [15:0] frame_len = 0;
  logic        busy;
  logic        ks_init_done = 0;
  logic        ks_rdy;
  logic        ks_valid = 0;
  logic [7:0]  ks_byte = 0;
  logic        ks_done;
  logic        in_valid = 0;
  logic        in_ready;
  logic [7:0]  in_data = 0;
  logic        out_valid;
  logic        out_ready = 0;
  logic [7:0]  out_data;
  logic        out_last;
  logic        ks_ovf;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] ks;
    logic [7:0] din;
    logic [7:0] dout;
    logic       last;
  } vec_t;

  vec_t vecs[3];

  rc4_stream_xor #(
    .KS_AW(4),
    .LEN_W(16)
`ifdef RC4_DROP_EN
    ,
    .DROP_N(2)
`endif
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .frame_len   (frame_len),
    .busy        (busy),
    .ks_init_done(ks_init_done),
    .ks_rdy      (ks_rdy),
    .ks_valid    (ks_valid),
    .ks_byte     (ks_byte),
    .ks_done     (ks_done),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .ks_ovf      (ks_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_ks_rdy"}, ks_rdy, 0);
    chk({nm, "_ks_done"}, ks_done, 0);
    chk({nm, "_in_ready"}, in_ready, 0);
    chk({nm, "_out_valid"}, out_valid, 0);
    chk({nm, "_out_last"}, out_last, 0);
    chk({nm, "_out_data"}, out_data, 0);
    chk({nm, "_ks_ovf"}, ks_ovf, 0);
  endtask

  task automatic start_frame(input logic [15:0] len);
    @(negedge clk);
    frame_start = 1;
    frame_len   = len;
    @(negedge clk);
    frame_start = 0;
  endtask

  // one strobe every other cycle; done = ks_done the cycle after
  task automatic strobe(input logic [7:0] b, output logic done);
    ks_valid = 1;
    ks_byte  = b;
    @(negedge clk);
    ks_valid = 0;
    #1 done = ks_done;
    @(negedge clk);
  endtask

  task automatic prime();
    logic d;
    ks_init_done = 0;
    @(negedge clk);
    chk("wait_init_rdy", ks_rdy, 0);
    chk("wait_init_busy", busy, 1);
    ks_init_done = 1;
    @(negedge clk);
    chk("start_rdy", ks_rdy, 1);
    strobe(8'h00, d);
    chk("stale_no_done", d, 0);
`ifdef RC4_DROP_EN
    chk("drop_rdy_low", ks_rdy, 0);
    strobe(8'h01, d);
    strobe(8'h02, d);
`endif
  endtask

  task automatic push_byte(input logic [7:0] din, input logic [7:0] dout,
                           input logic last, input string nm);
    in_valid = 1;
    in_data  = din;
    #1 chk({nm, "_in_ready"}, in_ready, 1);
    @(negedge clk);
    in_valid = 0;
    #1;
    chk({nm, "_out_valid"}, out_valid, 1);
    chk({nm, "_out_data"}, out_data, dout);
    chk({nm, "_out_last"}, out_last, last);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(nm, busy, 0);
  endtask

  task automatic run_basic(input string nm);
    logic d;
    start_frame(3);
    prime();
    foreach (vecs[i]) begin
      strobe(vecs[i].ks, d);
      chk({nm, "_ks_done"}, d, i == 2);
    end
    out_ready = 1;
    foreach (vecs[i])
      push_byte(vecs[i].din, vecs[i].dout, vecs[i].last, nm);
    wait_idle({nm, "_idle"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    logic d;
    vecs[0] = '{ks: 8'hA5, din: 8'h11, dout: 8'hB4, last: 1'b0};
    vecs[1] = '{ks: 8'h3C, din: 8'h22, dout: 8'h1E, last: 1'b0};
    vecs[2] = '{ks: 8'hFF, din: 8'h33, dout: 8'hCC, last: 1'b1};

    #2 rst = 0;
    repeat (2) @(negedge clk);
    chk_reset_vals("por");
    rst = 1;
    @(negedge clk);

    run_basic("basic");

    // backpressure
    start_frame(3);
    prime();
    foreach (vecs[i]) strobe(vecs[i].ks, d);
    out_ready = 0;
    push_byte(8'h11, 8'hB4, 0, "bp0");
    in_valid = 1;
    in_data  = 8'h22;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_data", out_data, 8'hB4);
      chk("bp_in_ready", in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1;
    push_byte(8'h22, 8'h1E, 0, "bp1");
    push_byte(8'h33, 8'hCC, 1, "bp2");
    wait_idle("bp_idle");

    // overflow: 20 kept strobes into a 16-deep FIFO
    start_frame(20);
    prime();
    in_valid  = 0;
    out_ready = 1;
    for (int i = 0; i < 20; i++) begin
      strobe(8'(i * 13 + 5), d);
      if (i == 15) chk("ovf_after16", ks_ovf, 0);
      if (i == 16) chk("ovf_after17", ks_ovf, 1);
      if (i == 19) chk("ovf_ks_done", d, 1);
    end
    for (int i = 0; i < 16; i++)
      push_byte(8'h5A, 8'(i * 13 + 5) ^ 8'h5A, 0, "ovf_data");
    chk("ovf_sticky", ks_ovf, 1);
    @(negedge clk);
    rst = 0;
    #1 chk("ovf_cleared", ks_ovf, 0);
    @(negedge clk);
    rst = 1;

    // zero length frame is ignored
    start_frame(0);
    @(negedge clk);
    chk("zero_busy", busy, 0);
    chk("zero_rdy", ks_rdy, 0);

    // frame_start while busy leaves rem_ks alone
    start_frame(3);
    prime();
    strobe(8'hA5, d);
    start_frame(10);
    strobe(8'h3C, d);
    chk("busy_no_early_done", d, 0);
    strobe(8'hFF, d);
    chk("busy_ks_done", d, 1);
    out_ready = 1;
    foreach (vecs[i])
      push_byte(vecs[i].din, vecs[i].dout, vecs[i].last, "busy");
    wait_idle("busy_idle");

    // reset mid-frame with two bytes still buffered
    start_frame(5);
    prime();
    foreach (vecs[i]) strobe(vecs[i].ks, d);
    out_ready = 0;
    push_byte(8'h11, 8'hB4, 0, "rst_pre");
    rst = 0;
    #1 chk_reset_vals("midrst");
    @(negedge clk);
    rst = 1;
    run_basic("post_rst");

`ifdef RC4_DROP_EN
    start_frame(1);
    prime();
    strobe(8'hA5, d);
    chk("drop_ks_done", d, 1);
    out_ready = 1;
    push_byte(8'h11, 8'hB4, 1, "drop");
    wait_idle("drop_idle");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
